// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial sequencer for a shared 4-bit ALU: latches wide operands,
// walks the nibbles LSB-first chaining carry, then pulses done.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start, op, cin    request, ALU op select, carry-in for nibble 0
//   opa, opb          wide operands (W = 4*NIBBLES), latched on accept
//   busy, done        RUN indicator, one-cycle completion pulse
//   result, cout_o    assembled result and final carry, held until next accept
//   alu_a/b/c/cin     drive to the external 4-bit ALU
//   alu_out, alu_cout combinational ALU response
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic                 cin,
    input  logic [4*NIBBLES-1:0] opa,
    input  logic [4*NIBBLES-1:0] opb,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout_o,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [1:0]           alu_c,
    output logic                 alu_cin,
    input  logic [3:0]           alu_out,
    input  logic                 alu_cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    opa_q, opa_d;
    logic [W-1:0]    opb_q, opb_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;

    // Bit offset of the active nibble.
    logic [IW+1:0]   base;
    assign base = {idx_q, 2'b00};

    // State register and datapath flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (idx_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        idx_d    = idx_q;
        carry_d  = carry_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        op_d     = op_q;
        result_d = result_q;
        cout_d   = cout_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d    = opa;
                    opb_d    = opb;
                    op_d     = op;
                    carry_d  = cin;
                    idx_d    = '0;
                    result_d = '0;
                end
            end
            S_RUN: begin
                result_d[base +: 4] = alu_out;
                carry_d             = alu_cout;
                if (idx_q == LAST) begin
                    idx_d  = '0;
                    cout_d = alu_cout;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs; the ALU sees zeros outside RUN so it stays quiet.
    always_comb begin
        busy    = (state_q == S_RUN);
        done    = (state_q == S_DONE);
        result  = result_q;
        cout_o  = cout_q;
        alu_c   = op_q;
        alu_a   = 4'h0;
        alu_b   = 4'h0;
        alu_cin = 1'b0;
        if (state_q == S_RUN) begin
            alu_a   = opa_q[base +: 4];
            alu_b   = opb_q[base +: 4];
            alu_cin = carry_q;
        end
    end

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Multi-cycle controller that computes a wide word operation on one shared 4-bit ALU datapath, one nibble per cycle.
- The datapath has ports a[3:0], b[3:0], c[1:0], cin, out[3:0] and cout.
- The block latches wide operands on a start request and walks the nibbles LSB-first, chaining the ALU carry between nibbles.
- It assembles the wide result and reports completion with a one-cycle done pulse. It sits between the lab top level and the 4-bit ALU instance.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand. Operand width W = 4*NIBBLES. Legal range 2..8.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- op  input  2  ALU operation select; passed opaquely to alu_c.
- cin  input  1  carry-in applied to nibble 0.
- opa  input  W  operand A.
- opb  input  W  operand B.
- busy  output  1  high while nibbles are being processed (RUN).
- done  output  1  one-cycle pulse; result and cout_o are valid from this cycle on.
- result  output  W  assembled result; held until the next accepted start.
- cout_o  output  1  carry out of the most significant nibble.
- alu_a  output  4  nibble of A driven to the ALU.
- alu_b  output  4  nibble of B driven to the ALU.
- alu_c  output  2  op select driven to the ALU.
- alu_cin  output  1  carry-in driven to the ALU.
- alu_out  input  4  ALU result, combinational from alu_a/alu_b/alu_c/alu_cin.
- alu_cout  input  1  ALU carry out, combinational.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, nibble index idx=0, carry register=0.
  - Latched operands and op cleared.
  - result=0, cout_o=0, busy=0, done=0.
  - Any operation in flight is abandoned; no done pulse is produced.
- States: IDLE, RUN, DONE. Registered state; busy and done decode from state.
- IDLE:
  - On a rising edge with start=1: latch opa, opb, op; set carry register to cin; idx=0; clear result to 0; go to RUN.
  - On start=0: stay in IDLE.
  - result and cout_o keep their previous values until a start is accepted.
- RUN (busy=1):
  - Outputs, combinational from registers: alu_a=opa_reg[4*idx+3:4*idx], alu_b=opb_reg[4*idx+3:4*idx], alu_c=op_reg, alu_cin=carry register.
  - Each edge: result[4*idx+3:4*idx] <= alu_out; carry register <= alu_cout; idx <= idx+1.
  - On the edge where idx==NIBBLES-1: cout_o <= alu_cout, idx <= 0, go to DONE.
  - start is ignored in RUN.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Unconditional transition to IDLE on the next edge.
  - start is ignored in the DONE cycle. A new operation needs start high in a later IDLE cycle.
- ALU drive outside RUN: alu_a=0, alu_b=0, alu_c=op_reg, alu_cin=0.
- Latency:
  - start sampled at edge E0. RUN occupies edges E1..E_NIBBLES. done is high in the cycle after edge E_NIBBLES.
  - Back-to-back issue interval is NIBBLES+2 cycles.
- Operand changes on opa/opb/op/cin after acceptance have no effect on the operation in flight.
- The carry is chained for every op code; the ALU defines what its cout means per op.
- idx width: ceil(log2(NIBBLES)). idx never exceeds NIBBLES-1.

Test Plan:
- Bench ALU model: c=2'b10 computes a+b+cin; c=2'b00 computes a&b with cout=0.
- Reset values: assert reset asynchronously with no clock edge -> result=0, cout_o=0, busy=0, done=0 immediately.
- Add with full carry ripple, NIBBLES=4: opa=16'hFFFF, opb=16'h0001, cin=0, op=2'b10 -> busy high 4 cycles; done pulses in the 5th cycle after start; result=16'h0000, cout_o=1. alu_cin sequence is 0,1,1,1.
- Add with carry-in and no final carry: opa=16'h1234, opb=16'h4321, cin=1, op=2'b10 -> result=16'h5556, cout_o=0.
- Operand change and start in RUN ignored: start an AND (opa=16'hF0F0, opb=16'hFF00, op=2'b00); in cycle 2 change opa to 16'h0000 and pulse start -> result=16'hF000, single done pulse, no second operation launched.
- Reset mid-operation, then immediate restart: assert reset during the third RUN cycle -> state IDLE, busy=0, no done pulse, result=0. Then start 16'h0001+16'h0001 -> result=16'h0002 after normal latency.
- Back-to-back ops and result hold: hold start high continuously -> operations accepted every 6 cycles. result stays stable from each done until the next acceptance edge.
